fp_stream_source: RTL and testbench

FP_STREAM_SOURCE -- requirements
Module: fp_stream_source

---
 rtl/fp_stream_source.sv | 142 ++++++++++++++
 tb/tb_fp_stream_source.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_stream_source.sv
// Frame source: streams a SIZE-word buffer out on an AXI-Stream master, then
// waits for a single result beat on the slave port and records latency.
module fp_stream_source #(
  parameter int unsigned SIZE       = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    start,
  output logic                    m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  input  logic                    s00_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    err,
  output logic [31:0]             cycles
);

  localparam int unsigned IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned CYC_W    = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RES = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [CYC_W-1:0]      cycles_q, cycles_d;

  logic [DATA_WIDTH-1:0] mem_q [SIZE];

  logic             wr_accept;
  logic             beat_fire;
  logic             res_fire;
  logic [CYC_W-1:0] cycles_inc;

  // Buffer only accepts loads while idle and inside the frame.
  assign wr_accept  = wr_en && (state_q == ST_IDLE) && (32'(wr_addr) < SIZE);
  assign beat_fire  = (state_q == ST_SEND) && m00_axis_tready;
  assign res_fire   = (state_q == ST_WAIT_RES) && s00_axis_tvalid;
  assign cycles_inc = (cycles_q == {CYC_W{1'b1}}) ? cycles_q : cycles_q + CYC_W'(1);

  always_ff @(posedge s00_axi_aclk) begin
    if (wr_accept) begin
      mem_q[IDX_W'(wr_addr)] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    cycles_d = cycles_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SEND;
          idx_d    = '0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          cycles_d = '0;
        end
      end
      ST_SEND: begin
        cycles_d = cycles_inc;
        if (beat_fire) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_WAIT_RES;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT_RES: begin
        cycles_d = cycles_inc;
        if (res_fire) begin
          result_d = s00_axis_tdata;
          err_d    = !s00_axis_tlast;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
    end
  end

  // Stream outputs decode the state register; data is a direct buffer read.
  assign m00_axis_tvalid = (state_q == ST_SEND);
  assign m00_axis_tdata  = mem_q[idx_q];
  assign m00_axis_tstrb  = {STRB_W{1'b1}};
  assign m00_axis_tlast  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
  assign s00_axis_tready = (state_q == ST_WAIT_RES);
  assign busy            = (state_q == ST_SEND) || (state_q == ST_WAIT_RES);

  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_fp_stream_source.sv
// Directed bench for fp_stream_source: frame streaming, stalls, result capture,
// dropped writes, ignored start and asynchronous mid-frame reset.
module tb_fp_stream_source;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic        m_tready;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_w [10];

  fp_stream_source #(.SIZE(10), .DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .start           (start),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tready (m_tready),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tready (s_tready),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .err             (err),
    .cycles          (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Runs one frame from the first SEND cycle; exercises stalls, stray inputs while busy.
  task automatic collect_frame(input bit toggle, input logic [31:0] exp_cyc);
    int beats = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] held_d = '0;
    logic held_l = 1'b0;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'h11111111;
    s_tlast  = 1'b1;
    while (beats < 10 && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("start_cycles", cycles, 32'd0);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
      end
      chk("send_tvalid", 32'(m_tvalid), 32'd1);
      chk("send_busy", 32'(busy), 32'd1);
      chk("send_s_tready", 32'(s_tready), 32'd0);
      chk("send_done", 32'(done), 32'd0);
      if (stalled) begin
        chk("stall_data", m_tdata, held_d);
        chk("stall_last", 32'(m_tlast), 32'(held_l));
      end
      if (m_tready) begin
        chk("beat_data", m_tdata, exp_w[beats]);
        chk("beat_last", 32'(m_tlast), (beats == 9) ? 32'd1 : 32'd0);
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held_d  = m_tdata;
        held_l  = m_tlast;
      end
      @(posedge clk);
      #1;
      cyc++;
      start   = (cyc == 3);
      wr_en   = (cyc == 4);
      wr_addr = 4'd3;
      wr_data = 32'hBAD0BAD0;
      if (beats >= 8) s_tvalid = 1'b0;
      if (toggle) m_tready = !m_tready;
    end
    start    = 1'b0;
    wr_en    = 1'b0;
    s_tvalid = 1'b0;
    chk("beat_count", 32'(beats), 32'd10);
    @(negedge clk);
    chk("wait_tvalid", 32'(m_tvalid), 32'd0);
    chk("wait_tlast", 32'(m_tlast), 32'd0);
    chk("wait_s_tready", 32'(s_tready), 32'd1);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_cycles", cycles, exp_cyc);
  endtask

  // Called at a negedge in WAIT_RES; presents the result after 'dly' idle edges.
  task automatic respond(input int dly, input logic [31:0] data, input logic last);
    repeat (dly) @(posedge clk);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_result(input logic exp_err, input logic [31:0] exp_res,
                              input logic [31:0] exp_cyc);
    @(negedge clk);
    chk("res_done", 32'(done), 32'd1);
    chk("res_err", 32'(err), 32'(exp_err));
    chk("res_data", result, exp_res);
    chk("res_cycles", cycles, exp_cyc);
    chk("res_busy", 32'(busy), 32'd0);
    chk("res_s_tready", 32'(s_tready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    exp_w[0] = 32'h3F800000; exp_w[1] = 32'h40000000; exp_w[2] = 32'h40400000;
    exp_w[3] = 32'h40800000; exp_w[4] = 32'h40A00000; exp_w[5] = 32'h40C00000;
    exp_w[6] = 32'h40E00000; exp_w[7] = 32'h41000000; exp_w[8] = 32'h41100000;
    exp_w[9] = 32'h41200000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tstrb", 32'(m_tstrb), 32'hF);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load frame with a stale word at 0, then rewrite it in the start cycle
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = (i == 0) ? 32'hDEADBEEF : exp_w[i];
      @(posedge clk);
      #1;
    end
    wr_addr = 4'd0;
    wr_data = exp_w[0];
    start   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    start = 1'b0;

    // Frame 1: tready held high, reply one cycle late
    collect_frame(1'b0, 32'd10);
    respond(1, 32'h425C0000, 1'b1);
    check_result(1'b0, 32'h425C0000, 32'd12);
    @(negedge clk);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_cycles", cycles, 32'd12);

    // Out-of-range write in IDLE must be dropped
    wr_en   = 1'b1;
    wr_addr = 4'd12;
    wr_data = 32'hBADBAD00;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // Frame 2: tready toggling, result with tlast low
    collect_frame(1'b1, 32'd19);
    respond(0, 32'h40490FDB, 1'b0);
    check_result(1'b1, 32'h40490FDB, 32'd20);

    // Frame 3: asynchronous reset after beat 5
    m_tready = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_rst_cycles", cycles, 32'd5);
    chk("pre_rst_data", m_tdata, exp_w[5]);
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_tvalid), 32'd0);
    chk("arst_tlast", 32'(m_tlast), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_s_tready", 32'(s_tready), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_cycles", cycles, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect_frame(1'b0, 32'd10);
    respond(0, 32'h3F800000, 1'b1);
    check_result(1'b0, 32'h3F800000, 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
